// File: rtl/recarga_uc_pkg.sv
// Shared constants for the reload control unit: state codes, default timing, helpers.
// The magazine counter is built only when RECARGA_MUNICAO_EN is defined.
package recarga_uc_pkg;

    localparam int T_RETORNO_DEFAULT   = 25_000_000;
    localparam int MUNICAO_MAX_DEFAULT = 6;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        ESPERA  = 4'd1,
        PREPARA = 4'd2,
        EMPURRA = 4'd3,
        RETORNO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    function automatic logic [2:0] dec_sat(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

endpackage

// File: rtl/recarga_timer.sv
// Servo return timer: counts while conta=1, fim flags the last cycle (count M-1).
// zera has priority over conta.
module recarga_timer #(
    parameter int M = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(M);

    logic [W-1:0] cnt_q, cnt_d;

    assign fim = (cnt_q == W'(M - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (zera)
            cnt_d = '0;
        else if (conta)
            cnt_d = fim ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/recarga_uc.sv
// Reload/fire control unit: Moore FSM driving the push servo plus optional magazine
// counter (enabled with RECARGA_MUNICAO_EN; otherwise firing is unlimited).
module recarga_uc
    import recarga_uc_pkg::*;
#(
    parameter int MUNICAO_MAX = MUNICAO_MAX_DEFAULT,
    parameter int T_RETORNO   = T_RETORNO_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       disparo,
    input  logic       recarregar,
    input  logic       fim_recarga,
    output logic       contar,
    output logic       zera_fd,
    output logic       pronto,
    output logic       ocupado,
    output logic       vazio,
    output logic       erro,
    output logic [2:0] municao,
    output logic [3:0] db_estado
);

    localparam logic [2:0] MUN_CHEIO = 3'(MUNICAO_MAX);

    estado_t state_q, state_d;
    logic    contar_q, contar_d;
    logic    zera_fd_q, zera_fd_d;
    logic    pronto_q, pronto_d;
    logic    ocupado_q, ocupado_d;
    logic    recarga_cmd;
    logic    fim_ret;

    recarga_timer #(.M(T_RETORNO)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (state_q != RETORNO),
        .conta (state_q == RETORNO),
        .fim   (fim_ret)
    );

    // Outputs are registered from the next state so they line up with the state itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL: state_d = ESPERA;
            ESPERA:  if (!recarga_cmd && disparo && !vazio) state_d = PREPARA;
            PREPARA: state_d = EMPURRA;
            EMPURRA: if (fim_recarga) state_d = RETORNO;
            RETORNO: if (fim_ret) state_d = FIM;
            FIM:     state_d = ESPERA;
            default: state_d = INICIAL;
        endcase
        contar_d  = (state_d == EMPURRA);
        zera_fd_d = (state_d == PREPARA);
        pronto_d  = (state_d == FIM);
        ocupado_d = (state_d == PREPARA) || (state_d == EMPURRA) ||
                    (state_d == RETORNO) || (state_d == FIM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= INICIAL;
            contar_q  <= 1'b0;
            zera_fd_q <= 1'b0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            contar_q  <= contar_d;
            zera_fd_q <= zera_fd_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
        end
    end

`ifdef RECARGA_MUNICAO_EN
    logic [2:0] municao_q, municao_d;
    logic       erro_q, erro_d;

    assign recarga_cmd = recarregar;
    assign vazio       = (municao_q == 3'd0);

    // Refill beats fire in the same ESPERA cycle.
    always_comb begin
        municao_d = municao_q;
        erro_d    = 1'b0;
        if (state_q == INICIAL)
            municao_d = MUN_CHEIO;
        else if (state_q == ESPERA) begin
            if (recarregar)
                municao_d = MUN_CHEIO;
            else if (disparo && vazio)
                erro_d = 1'b1;
        end else if (state_q == EMPURRA && fim_recarga)
            municao_d = dec_sat(municao_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            municao_q <= 3'd0;
            erro_q    <= 1'b0;
        end else begin
            municao_q <= municao_d;
            erro_q    <= erro_d;
        end
    end

    assign municao = municao_q;
    assign erro    = erro_q;
`else
    logic unused_recarregar;

    assign unused_recarregar = recarregar;
    assign recarga_cmd       = 1'b0;
    assign vazio             = 1'b0;
    assign erro              = 1'b0;
    assign municao           = MUN_CHEIO;
`endif

    assign contar    = contar_q;
    assign zera_fd   = zera_fd_q;
    assign pronto    = pronto_q;
    assign ocupado   = ocupado_q;
    assign db_estado = state_q;

endmodule

// File: doc/recarga_uc.md
RECARGA_UC -- requirements
Module: recarga_uc

Interface
REQ-001 Parameter MUNICAO_MAX, default 6: magazine capacity in shots, range 1..7.
REQ-002 Parameter T_RETORNO, default 25_000_000: servo return time in clock cycles (0.5 s at 50 MHz), minimum 2.
REQ-003 clock  input  1  system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 disparo  input  1  fire request; level-sampled in ESPERA only.
REQ-006 recarregar  input  1  magazine refill command; level-sampled in ESPERA only.
REQ-007 fim_recarga  input  1  push-time-elapsed flag from the reload servo datapath.
REQ-008 contar  output  1  servo datapath count enable; 1 drives the servo to the push position.
REQ-009 zera_fd  output  1  synchronous clear for the servo datapath timer.
REQ-010 pronto  output  1  one-cycle pulse when a fire cycle completes.
REQ-011 ocupado  output  1  high while a fire cycle is in progress.
REQ-012 vazio  output  1  high when the magazine count is 0.
REQ-013 erro  output  1  one-cycle pulse when disparo is sampled with an empty magazine.
REQ-014 municao  output  3  remaining shots.
REQ-015 db_estado  output  4  current state code.

Function
REQ-016 The FSM SHALL use Moore states with these codes: INICIAL=0, ESPERA=1, PREPARA=2, EMPURRA=3, RETORNO=4, FIM=5; codes 6..15 SHALL go to INICIAL on the next edge.
REQ-017 INICIAL SHALL go to ESPERA unconditionally, and municao SHALL load MUNICAO_MAX on that transition.
REQ-018 In ESPERA, recarregar=1 SHALL load municao=MAX and stay in ESPERA; recarregar has priority over disparo in the same cycle.
REQ-019 In ESPERA, disparo=1 with vazio=0 SHALL go to PREPARA; disparo=1 with vazio=1 SHALL stay in ESPERA and pulse erro the next cycle.
REQ-020 PREPARA SHALL assert zera_fd=1 for exactly one cycle, then go to EMPURRA.
REQ-021 EMPURRA SHALL hold contar=1 until fim_recarga=1 is sampled, then go to RETORNO and decrement municao by 1, saturating at 0.
REQ-022 RETORNO SHALL hold contar=0 and run an internal timer from 0; at T_RETORNO-1 it SHALL go to FIM. Total RETORNO dwell is T_RETORNO cycles.
REQ-023 FIM SHALL assert pronto=1 for one cycle, then go to ESPERA.
REQ-024 ocupado SHALL be 1 in PREPARA, EMPURRA, RETORNO and FIM, and 0 otherwise.
REQ-025 disparo and recarregar SHALL be ignored outside ESPERA; requests are not queued.
REQ-026 fim_recarga SHALL be ignored outside EMPURRA.
REQ-027 Minimum fire-cycle latency, from disparo sampled to pronto, SHALL be 1 (PREPARA) + push cycles + T_RETORNO + 1 cycles.

Reset
REQ-028 Asserting reset=0 SHALL asynchronously set: state=INICIAL, municao=0, return timer=0, and contar, zera_fd, pronto, ocupado, erro=0.
REQ-029 Reset asserted mid-cycle (any state) SHALL abort the cycle with no pronto pulse and no decrement.

Configuration
REQ-030 With RECARGA_MUNICAO_EN defined, the magazine counter, vazio, erro and recarregar behave as in REQ-017..REQ-021.
REQ-031 Without RECARGA_MUNICAO_EN: no counter is built; municao is tied to MUNICAO_MAX, vazio=0, erro=0, recarregar is ignored, and firing is unlimited.

Structure
REQ-032 A shared package SHALL hold the state-code constants and the default timing constant T_RETORNO_DEFAULT=25_000_000.
REQ-033 The return timer SHALL be a sub-module instance of recarga_timer (parameter M=T_RETORNO, inputs zera/conta, output fim); all other logic stays in recarga_uc.

Verification (MUNICAO_MAX=2, T_RETORNO=4, bench-driven fim_recarga)
REQ-034 Release reset, no inputs -> after 2 edges db_estado=1, municao=2, vazio=0, all pulses 0.
REQ-035 disparo 1 cycle, fim_recarga raised 3 cycles after contar rises -> zera_fd for 1 cycle, contar high for 3 cycles, RETORNO for 4 cycles, pronto pulse, municao=1.
REQ-036 Two full fire cycles, then disparo -> vazio=1, erro pulse for 1 cycle, state stays 1, contar stays 0.
REQ-037 disparo and recarregar high in the same ESPERA cycle with municao=0 -> municao=2, no fire cycle starts.
REQ-038 reset=0 pulse during EMPURRA -> outputs clear immediately, municao=0, no pronto; after release the FSM returns to ESPERA with municao=2.
REQ-039 disparo held during RETORNO, fim_recarga pulsed in ESPERA -> no extra cycle and no state change; a held disparo restarts only after FIM.
